// File: rtl/rt_rgu_stream.sv
// rt_rgu_stream: streaming frame-level ray generation unit.
// Scans a WIDTH x HEIGHT image in raster order and emits one primary ray per
// pixel over a valid/ready handshake at up to one ray per cycle. Pixel centres
// are formed incrementally (+du per column, +dv per row) instead of multiplying.
// Optional feature macro: RT_RGU_JITTER_EN adds LFSR jitter to the direction LSBs.
module rt_rgu_stream #(
    parameter int unsigned IW = 16,
    parameter int unsigned QW = 16,
    parameter int unsigned CW = 12
`ifdef RT_RGU_JITTER_EN
    ,
    parameter int unsigned JB = 4
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [CW-1:0]             img_width,
    input  logic [CW-1:0]             img_height,
    input  logic [2:0][IW+QW-1:0]     pixel_00_loc,
    input  logic [2:0][IW+QW-1:0]     pixel_delta_u,
    input  logic [2:0][IW+QW-1:0]     pixel_delta_v,
    input  logic [2:0][IW+QW-1:0]     camera_center,
    output logic                      ray_valid,
    input  logic                      ray_ready,
    output logic [2:0][IW+QW-1:0]     ray_origin,
    output logic [2:0][IW+QW-1:0]     ray_direction,
    output logic [CW-1:0]             ray_x,
    output logic [CW-1:0]             ray_y,
    output logic                      ray_last
);

    localparam int unsigned WL = IW + QW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t              state;
    logic [CW-1:0]       w_q;
    logic [CW-1:0]       h_q;
    logic [2:0][WL-1:0]  du_q;
    logic [2:0][WL-1:0]  dv_q;
    logic [2:0][WL-1:0]  center_q;
    logic [2:0][WL-1:0]  cur;
    logic [2:0][WL-1:0]  row_base;

    logic                hs;
    logic                at_wrap;
    logic                at_end;
    logic                nxt_last;
    logic [CW-1:0]       nxt_x;
    logic [CW-1:0]       nxt_y;
    logic [2:0][WL-1:0]  nxt_cur;
    logic [2:0][WL-1:0]  nxt_row;
    logic [2:0][WL-1:0]  nxt_dir;

`ifdef RT_RGU_JITTER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0]         lfsr;
    logic [15:0]         nxt_lfsr;
    logic [WL-1:0]       jit;

    // One Fibonacci step, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction
`endif

    // Next pixel position, centre and direction for the ray to be registered.
    always_comb begin
        hs       = ray_valid & ray_ready;
        at_wrap  = (ray_x == w_q - CW'(1));
        at_end   = at_wrap && (ray_y == h_q - CW'(1));
        nxt_x    = ray_x;
        nxt_y    = ray_y;
        nxt_cur  = cur;
        nxt_row  = row_base;
        if (state == S_RUN && hs && !at_end) begin
            if (at_wrap) begin
                nxt_x = '0;
                nxt_y = ray_y + CW'(1);
                for (int i = 0; i < 3; i++) begin
                    nxt_row[i] = row_base[i] + dv_q[i];
                end
                nxt_cur = nxt_row;
            end else begin
                nxt_x = ray_x + CW'(1);
                for (int i = 0; i < 3; i++) begin
                    nxt_cur[i] = cur[i] + du_q[i];
                end
            end
        end
        nxt_last = (nxt_x == w_q - CW'(1)) && (nxt_y == h_q - CW'(1));
`ifdef RT_RGU_JITTER_EN
        nxt_lfsr = hs ? lfsr_step(lfsr) : lfsr;
        jit      = {{(WL-JB){nxt_lfsr[JB-1]}}, nxt_lfsr[JB-1:0]};
        for (int i = 0; i < 3; i++) begin
            nxt_dir[i] = nxt_cur[i] - center_q[i] + jit;
        end
`else
        for (int i = 0; i < 3; i++) begin
            nxt_dir[i] = nxt_cur[i] - center_q[i];
        end
`endif
    end

    // Frame FSM, configuration latch and registered ray outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ray_valid     <= 1'b0;
            ray_origin    <= '0;
            ray_direction <= '0;
            ray_x         <= '0;
            ray_y         <= '0;
            ray_last      <= 1'b0;
            w_q           <= '0;
            h_q           <= '0;
            du_q          <= '0;
            dv_q          <= '0;
            center_q      <= '0;
            cur           <= '0;
            row_base      <= '0;
`ifdef RT_RGU_JITTER_EN
            lfsr          <= LFSR_SEED;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        w_q      <= img_width;
                        h_q      <= img_height;
                        du_q     <= pixel_delta_u;
                        dv_q     <= pixel_delta_v;
                        center_q <= camera_center;
                        cur      <= pixel_00_loc;
                        row_base <= pixel_00_loc;
                        ray_x    <= '0;
                        ray_y    <= '0;
`ifdef RT_RGU_JITTER_EN
                        lfsr     <= LFSR_SEED;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_q == '0 || h_q == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        state         <= S_RUN;
                        ray_valid     <= 1'b1;
                        ray_origin    <= center_q;
                        ray_direction <= nxt_dir;
                        ray_last      <= nxt_last;
                    end
                end
                S_RUN: begin
                    if (hs) begin
`ifdef RT_RGU_JITTER_EN
                        lfsr <= nxt_lfsr;
`endif
                        if (at_end) begin
                            state     <= S_IDLE;
                            ray_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cur           <= nxt_cur;
                            row_base      <= nxt_row;
                            ray_x         <= nxt_x;
                            ray_y         <= nxt_y;
                            ray_direction <= nxt_dir;
                            ray_last      <= nxt_last;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rt_rgu_stream.sv
// Self-checking bench for rt_rgu_stream: directed frames plus randomized
// frames checked against a closed-form model (dir = p00 + x*du + y*dv - c).
module tb_rt_rgu_stream;

    localparam int unsigned CW = 12;
    localparam int unsigned WL = 32;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] MONE = 32'hFFFF_0000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [CW-1:0]        img_width;
    logic [CW-1:0]        img_height;
    logic [2:0][WL-1:0]   pixel_00_loc;
    logic [2:0][WL-1:0]   pixel_delta_u;
    logic [2:0][WL-1:0]   pixel_delta_v;
    logic [2:0][WL-1:0]   camera_center;
    logic                 ray_valid;
    logic                 ray_ready;
    logic [2:0][WL-1:0]   ray_origin;
    logic [2:0][WL-1:0]   ray_direction;
    logic [CW-1:0]        ray_x;
    logic [CW-1:0]        ray_y;
    logic                 ray_last;

    int n_checks = 0;
    int n_fail   = 0;

    rt_rgu_stream dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .img_width     (img_width),
        .img_height    (img_height),
        .pixel_00_loc  (pixel_00_loc),
        .pixel_delta_u (pixel_delta_u),
        .pixel_delta_v (pixel_delta_v),
        .camera_center (camera_center),
        .ray_valid     (ray_valid),
        .ray_ready     (ray_ready),
        .ray_origin    (ray_origin),
        .ray_direction (ray_direction),
        .ray_x         (ray_x),
        .ray_y         (ray_y),
        .ray_last      (ray_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return (s >> 1) | (16'(fb) << 15);
    endfunction

    // Expected direction of pixel (x,y); jitter word l applies only when enabled.
    function automatic logic [2:0][31:0] model_dir(input logic [2:0][31:0] p, input logic [2:0][31:0] du,
                                                   input logic [2:0][31:0] dv, input logic [2:0][31:0] c,
                                                   input int x, input int y, input logic [15:0] l);
        logic [2:0][31:0] d;
        for (int i = 0; i < 3; i++) begin
            d[i] = p[i] + 32'(x) * du[i] + 32'(y) * dv[i] - c[i];
`ifdef RT_RGU_JITTER_EN
            d[i] = d[i] + {{28{l[3]}}, l[3:0]};
`endif
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, 96'(busy), 96'(0));
        check({nm, "_done"}, 96'(done), 96'(0));
        check({nm, "_valid"}, 96'(ray_valid), 96'(0));
        check({nm, "_xy"}, 96'({ray_x, ray_y, ray_last}), 96'(0));
        check({nm, "_origin"}, ray_origin, 96'(0));
        check({nm, "_dir"}, ray_direction, 96'(0));
    endtask

    task automatic scramble_cfg();
        img_width  = CW'($urandom);
        img_height = CW'($urandom);
        for (int i = 0; i < 3; i++) begin
            pixel_00_loc[i]  = $urandom;
            pixel_delta_u[i] = $urandom;
            pixel_delta_v[i] = $urandom;
            camera_center[i] = $urandom;
        end
    endtask

    // Run one frame from IDLE; checks every presented cycle and the done/busy tail.
    task automatic run_frame(input string nm, input logic [11:0] w, input logic [11:0] h,
                             input logic [2:0][31:0] p, input logic [2:0][31:0] du,
                             input logic [2:0][31:0] dv, input logic [2:0][31:0] c,
                             input int rdy_pct, input int stall_idx, input bit inj_start);
        int n, idx, cyc, stall;
        bit pend;
        logic [15:0] ml;
        n = int'(w) * int'(h);
        idx = 0; cyc = 0; stall = 0;
        pend = (n == 0);
        ml = 16'hACE1;
        img_width = w; img_height = h;
        pixel_00_loc = p; pixel_delta_u = du; pixel_delta_v = dv; camera_center = c;
        ray_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_load_busy"}, 96'(busy), 96'(1));
        check({nm, "_load_valid"}, 96'(ray_valid), 96'(0));
        scramble_cfg();
        forever begin
            tick();
            cyc++;
            if (pend) begin
                check({nm, "_done"}, 96'({done, busy, ray_valid}), 96'(3'b110));
                tick();
                check({nm, "_after_done"}, 96'({done, busy}), 96'(0));
                break;
            end
            if (cyc > n * 40 + 20) begin
                check({nm, "_timeout_rays"}, 96'(idx), 96'(n));
                break;
            end
            check({nm, "_run_ctl"}, 96'({done, busy, ray_valid}), 96'(3'b011));
            check({nm, "_x"}, 96'(ray_x), 96'(idx % int'(w)));
            check({nm, "_y"}, 96'(ray_y), 96'(idx / int'(w)));
            check({nm, "_last"}, 96'(ray_last), 96'(idx == n - 1));
            check({nm, "_origin"}, ray_origin, c);
            check({nm, "_dir"}, ray_direction,
                  model_dir(p, du, dv, c, idx % int'(w), idx / int'(w), ml));
            if (idx == stall_idx && stall < 3) begin
                ray_ready = 1'b0;
                stall++;
            end else begin
                ray_ready = ($urandom_range(99) < 32'(rdy_pct));
            end
            start = inj_start ? 1'($urandom) : 1'b0;
            if (ray_ready) begin
                idx++;
                ml = model_lfsr(ml);
                if (idx == n) begin
                    pend = 1'b1;
                    start = 1'b0;
                end
            end
        end
        ray_ready = 1'b0;
        start = 1'b0;
    endtask

    logic [2:0][31:0] p, du, dv, c, z;

    initial begin
        reset = 1'b1; start = 1'b0; ray_ready = 1'b0;
        scramble_cfg();
        z = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic 2x2 frame, consumer always ready.
        p  = '{MONE, 32'h0, 32'h0};
        du = '{32'h0, 32'h0, ONE};
        dv = '{32'h0, MONE, 32'h0};
        run_frame("basic", 12'd2, 12'd2, p, du, dv, z, 100, -1, 1'b0);

        // Same frame with ray (1,0) held for three cycles.
        run_frame("bp", 12'd2, 12'd2, p, du, dv, z, 100, 1, 1'b0);

        // Empty frames.
        run_frame("empty_w", 12'd0, 12'd5, p, du, dv, z, 100, -1, 1'b0);
        run_frame("empty_h", 12'd3, 12'd0, p, du, dv, z, 100, -1, 1'b0);

        // Reset after the first handshake abandons the frame silently.
        img_width = 12'd2; img_height = 12'd2;
        pixel_00_loc = p; pixel_delta_u = du; pixel_delta_v = dv; camera_center = z;
        start = 1'b1;
        tick();
        start = 1'b0;
        ray_ready = 1'b1;
        tick();
        check("rst_first_valid", 96'(ray_valid), 96'(1));
        tick();
        check("rst_second_x", 96'(ray_x), 96'(1));
        ray_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("rst_mid");
        repeat (4) begin
            tick();
            check("rst_no_done", 96'({done, ray_valid}), 96'(0));
        end

        // New start after reset uses freshly sampled configuration.
        c = '{32'h0002_0000, 32'h0, 32'h0001_8000};
        run_frame("restart", 12'd3, 12'd2, p, du, dv, c, 100, -1, 1'b0);

        // Reset and start together: reset wins.
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", 96'(busy), 96'(0));
        tick();
        check("rst_start_idle", 96'({busy, ray_valid}), 96'(0));

        // Start pulses mid-frame are ignored; x wraps past 0x7FFFFFFF.
        p  = '{32'h0, 32'h0, 32'h7FFF_FFFF};
        du = '{32'h0, 32'h0, 32'h1};
        run_frame("wrap", 12'd3, 12'd2, p, du, dv, z, 70, -1, 1'b1);

        // Randomized frames with random backpressure and stray starts.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) begin
                p[i] = $urandom; du[i] = $urandom; dv[i] = $urandom; c[i] = $urandom;
            end
            run_frame("rand", 12'($urandom_range(1, 5)), 12'($urandom_range(1, 5)),
                      p, du, dv, c, 60, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
